data_memory_controller: RTL
===========================

DATA_MEMORY_CONTROLLER -- requirements
Module: data_memory_controller

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64: number of 32-bit words in the data store, a power of two.
REQ-002 The block SHALL have parameter BASE_ADDR, default 1024: byte address mapped to word 0.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 3: wait states per access, legal range 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port MEM_R_EN, input, 1 bit: read request from the memory stage.
REQ-007 The block SHALL have port MEM_W_EN, input, 1 bit: write request from the memory stage.
REQ-008 The block SHALL have port address, input, `ADDRESS_LEN bits: byte address, which is ALU_Res of the memory stage.
REQ-009 The block SHALL have port wdata, input, `WORD_LEN bits: store data.
REQ-010 The block SHALL have port rdata, output, `WORD_LEN bits: load data, which drives memory_out.
REQ-011 The block SHALL have port ready, output, 1 bit: high means the access is complete or no access is pending; low means the pipeline freezes.
REQ-012 The block SHALL have port err, output, 1 bit: out-of-range pulse (see Configuration).

Function
REQ-013 Word index SHALL be (address - BASE_ADDR) >> 2, taken modulo DEPTH; address bits [1:0] SHALL be ignored.
REQ-014 The FSM SHALL have the states IDLE, WAIT and DONE.
REQ-015 In IDLE with MEM_R_EN or MEM_W_EN high, the block SHALL latch address, wdata and the request type, load the counter with WAIT_CYCLES-1, and go to WAIT.
REQ-016 In WAIT, the counter SHALL decrement each cycle; at zero the block SHALL perform the access and go to DONE on the next edge.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-018 ready SHALL be combinational: high when (IDLE and no request) or in DONE; low otherwise, including the IDLE cycle in which a request is presented.
REQ-019 Latency SHALL be: a request presented in IDLE at cycle N gives ready high at cycle N+WAIT_CYCLES+1.
REQ-020 rdata SHALL be a register, updated with mem[index] at the WAIT-to-DONE edge for reads, and held until the next read completes.
REQ-021 A write SHALL update mem[index] with the latched wdata at the WAIT-to-DONE edge; rdata SHALL be unchanged.
REQ-022 If MEM_R_EN and MEM_W_EN are both high, the access SHALL be treated as a write.
REQ-023 Request inputs SHALL be ignored outside IDLE; only the latched copies SHALL be used.
REQ-024 A request still present in the IDLE cycle after DONE SHALL be treated as a new access.
REQ-025 The block SHALL NOT stall the pipeline when no request is present.

Reset
REQ-026 When rst is low at a rising edge, the block SHALL set: state IDLE, counter 0, rdata 0, err 0, latched request cleared.
REQ-027 During reset, ready SHALL be 1 (IDLE with no request is not counted during reset).
REQ-028 Reset SHALL NOT clear memory contents.
REQ-029 Reset asserted during WAIT SHALL abort the access with no memory write.

Configuration
REQ-030 Macro DMEM_BOUNDS_CHECK_EN defined: an address below BASE_ADDR or at/above BASE_ADDR+4*DEPTH SHALL suppress the write, load rdata with 0 on reads, and pulse err high for the DONE cycle; timing SHALL be unchanged.
REQ-031 Macro DMEM_BOUNDS_CHECK_EN undefined: the index SHALL wrap modulo DEPTH per REQ-013, and err SHALL be tied to 0.

Verification
REQ-032 Reset: rst low for 2 cycles, then high -> rdata=0, err=0, ready=1.
REQ-033 Write then read: WAIT_CYCLES=3; write 0xDEADBEEF to 1028, then read 1028 -> each ready low 4 cycles; rdata=0xDEADBEEF in the read's DONE cycle.
REQ-034 Simultaneous enables: MEM_R_EN=MEM_W_EN=1, address 1032, wdata 0x5 -> mem[2]=5 and rdata unchanged.
REQ-035 Back-to-back accesses: read request held high after DONE -> second access starts, ready low again for 4 cycles.
REQ-036 Reset mid-operation: rst low in 2nd WAIT cycle of a write of 0x1234 to 1036 -> next read of 1036 returns the prior value, not 0x1234.
REQ-037 Bounds: write to 1024+4*DEPTH -> with DMEM_BOUNDS_CHECK_EN, err pulses 1 cycle and mem[0] is unchanged; without it, mem[0] is written and err stays 0.

Source files
------------

// File: rtl/data_memory_controller.sv
// Wait-stated data memory for the pipeline's memory stage: latches one access, holds ready low while it runs.
// Optional define DMEM_BOUNDS_CHECK_EN turns out-of-window accesses into an err pulse instead of wrapping.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module data_memory_controller #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MEM_R_EN,
    input  logic                    MEM_W_EN,
    input  logic [`ADDRESS_LEN-1:0] address,
    input  logic [`WORD_LEN-1:0]    wdata,
    output logic [`WORD_LEN-1:0]    rdata,
    output logic                    ready,
    output logic                    err
);
    localparam int unsigned AW   = `ADDRESS_LEN;
    localparam int unsigned DW   = `WORD_LEN;
    localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);
    localparam logic [3:0]    CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [DW-1:0]   mem [DEPTH];

    logic            req;
    logic            access;
    logic            in_range;
    logic            mem_we;
    logic [AW-1:0]   off;
    logic [IDXW-1:0] idx;

    assign req    = MEM_R_EN | MEM_W_EN;
    assign access = (state_q == S_WAIT) && (cnt_q == '0);
    assign off    = addr_q - BASE;
    // Truncating the word offset to IDXW bits is the modulo-DEPTH wrap.
    assign idx    = IDXW'(off >> 2);

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [AW:0] SPAN = (AW+1)'(4 * DEPTH);
    assign in_range = (addr_q >= BASE) && ({1'b0, off} < SPAN);
`else
    assign in_range = 1'b1;
`endif

    assign mem_we = access && wr_q && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                    wr_d    = MEM_W_EN;
                    addr_d  = address;
                    wdata_d = wdata;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (!wr_q) rdata_d = in_range ? mem[idx] : '0;
                    err_d = !in_range;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory has no reset; a reset during WAIT must block the pending write.
    always_ff @(posedge clk) begin
        if (rst && mem_we) mem[idx] <= wdata_q;
    end

    assign ready = !rst || ((state_q == S_IDLE) && !req) || (state_q == S_DONE);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule
